// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage turning loads/stores into a req/ack data-memory transaction, stalling the front of the pipe while it is outstanding
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        RegWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic [31:0] ALUResultW_d,
  output logic [31:0] ReadDataW_d,
  output logic [31:0] PCPlus4W_d,
  output logic [4:0]  RdW_d,
  output logic        RegWriteW_d,
  output logic        MemFault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic [31:0] rdata_q, ld_ext, sh, wdata;
  logic [3:0] be;
  logic fault, mem_op, align_ok, legal, start, tmo_hit;
  always_comb begin
    mem_op = MemReadM | MemWriteM;
    align_ok = funct3M[1:0] == 2'b00 ? 1'b1 :
               funct3M[1:0] == 2'b01 ? !ALUResultM[0] : ALUResultM[1:0] == 2'b00;
    legal = align_ok && funct3M[1:0] != 2'b11 && !(funct3M[2] && (MemWriteM || funct3M[1]));
    start = state == IDLE && mem_op && legal;
    tmo_hit = state == BUSY && !dmem_ack && cnt == CW'(TIMEOUT - 1);
    be = funct3M[1:0] == 2'b00 ? 4'b0001 << ALUResultM[1:0] :
         funct3M[1:0] == 2'b01 ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
            funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
    sh = dmem_rdata >> {off_q, 3'b000};
    ld_ext = f3_q[1] ? sh :
             f3_q[0] ? {{16{!f3_q[2] & sh[15]}}, sh[15:0]} : {{24{!f3_q[2] & sh[7]}}, sh[7:0]};
    state_n = state == IDLE ? (start ? BUSY : IDLE) :
              state == BUSY ? ((dmem_ack || tmo_hit) ? DONE : BUSY) : IDLE;
    StallM = start || state == BUSY;
    MemFault = (state == IDLE && mem_op && !legal) || (state == DONE && fault);
    RdW_d = StallM ? 5'd0 : RdM;
    RegWriteW_d = state == DONE ? RegWriteM & !fault : state == IDLE && !mem_op && RegWriteM;
    ReadDataW_d = state == DONE ? rdata_q : 32'd0;
    ALUResultW_d = ALUResultM;
    PCPlus4W_d = PCPlus4M;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      off_q <= '0;
      f3_q <= '0;
      cnt <= '0;
      rdata_q <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        dmem_req <= 1'b1;
        dmem_we <= MemWriteM;
        dmem_addr <= {ALUResultM[31:2], 2'b00};
        dmem_be <= be;
        dmem_wdata <= wdata;
        off_q <= ALUResultM[1:0];
        f3_q <= funct3M;
        cnt <= '0;
        fault <= 1'b0;
      end else if (state == BUSY) begin
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          rdata_q <= ld_ext;
        end else if (tmo_hit) begin
          dmem_req <= 1'b0;
          fault <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end else if (state == DONE) fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random instruction stream into the MEM stage, scoreboard of expected retirements checked by a monitor
module tb_mem_access_stage;
  localparam int TO = 4;
  logic clk = 0, reset = 1;
  logic MemReadM = 0, MemWriteM = 0, RegWriteM = 0;
  logic [2:0] funct3M = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, PCPlus4M = 0, dmem_rdata = 0;
  logic [4:0] RdM = 0;
  logic dmem_ack = 0;
  logic dmem_req, dmem_we, StallM, RegWriteW_d, MemFault;
  logic [31:0] dmem_addr, dmem_wdata, ALUResultW_d, ReadDataW_d, PCPlus4W_d;
  logic [3:0] dmem_be;
  logic [4:0] RdW_d;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .funct3M(funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .StallM(StallM), .ALUResultW_d(ALUResultW_d),
    .ReadDataW_d(ReadDataW_d), .PCPlus4W_d(PCPlus4W_d), .RdW_d(RdW_d),
    .RegWriteW_d(RegWriteW_d), .MemFault(MemFault)
  );

  typedef struct {
    bit chk_rd, chk_data;
    logic [4:0] rd;
    logic rw, fault, we;
    logic [31:0] alu, pc4, data, addr, wdata;
    logic [3:0] be;
    int stalls, nreq;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0, n_err = 0, stall_cnt = 0, req_cnt = 0;
  bit mon_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (dmem_req) begin
          req_cnt++;
          if (exp_q.size() > 0) begin
            chk("dmem_addr", dmem_addr, exp_q[0].addr);
            chk("dmem_be", dmem_be, exp_q[0].be);
            chk("dmem_wdata", dmem_wdata, exp_q[0].wdata);
            chk("dmem_we", dmem_we, exp_q[0].we);
          end
        end
        if (StallM) begin
          stall_cnt++;
          chk("bubble_rd", RdW_d, 0);
          chk("bubble_regwrite", RegWriteW_d, 0);
          chk("bubble_fault", MemFault, 0);
        end else begin
          chk("retire_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_rd) chk("rd", RdW_d, e.rd);
            if (e.chk_data) chk("read_data", ReadDataW_d, e.data);
            chk("regwrite", RegWriteW_d, e.rw);
            chk("alu_result", ALUResultW_d, e.alu);
            chk("pc_plus4", PCPlus4W_d, e.pc4);
            chk("mem_fault", MemFault, e.fault);
            chk("stall_cycles", stall_cnt, e.stalls);
            chk("req_cycles", req_cnt, e.nreq);
          end
          stall_cnt = 0;
          req_cnt = 0;
        end
      end
    end
  end

  task automatic issue(bit mr, bit mw, bit rw, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                       logic [4:0] rd, int delay, logic [31:0] rdata);
    exp_t e;
    int n, off;
    bit memop, legal, tmo;
    longint raw;
    logic [31:0] pc;
    pc = $urandom;
    n = 1 << f3[1:0];
    off = int'(addr[1:0]);
    memop = mr | mw;
    legal = (mw ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) && (off % n == 0);
    tmo = delay >= TO;
    e = '{default: 0};
    e.alu = addr;
    e.pc4 = pc;
    e.addr = {addr[31:2], 2'b00};
    e.we = mw;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = i >= off && i < off + n;
      e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    if (!memop) begin
      e.chk_rd = 1; e.rd = rd; e.rw = rw; e.chk_data = 1; e.data = 0;
    end else if (!legal) begin
      e.rw = 0; e.fault = 1;
    end else begin
      e.chk_rd = 1; e.rd = rd; e.rw = rw & !tmo; e.fault = tmo;
      e.stalls = tmo ? TO + 1 : delay + 2;
      e.nreq = tmo ? TO : delay + 1;
      if (mr && !tmo) begin
        raw = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (!f3[2] && n < 4 && raw >= (longint'(1) << (8 * n - 1))) raw -= longint'(1) << (8 * n);
        e.chk_data = 1;
        e.data = raw[31:0];
      end
    end
    exp_q.push_back(e);
    MemReadM = mr; MemWriteM = mw; RegWriteM = rw; funct3M = f3;
    ALUResultM = addr; WriteDataM = wd; PCPlus4M = pc; RdM = rd;
    dmem_ack = ($urandom % 4) == 0;
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    if (memop && legal) begin
      for (int w = 0; w < TO; w++) begin
        dmem_ack = w == delay;
        dmem_rdata = (w == delay) ? rdata : $urandom;
        @(posedge clk); #1;
        if (w == delay) break;
      end
      dmem_ack = ($urandom % 4) == 0;
      dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  task automatic random_ops(int cnt);
    int kind;
    logic [31:0] a;
    for (int k = 0; k < cnt; k++) begin
      kind = $urandom % 3;
      a = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      issue(kind == 1, kind == 2, kind != 2, 3'($urandom % 8), a, $urandom, 5'($urandom),
            $urandom_range(0, TO), $urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", dmem_req, 0);
    chk("reset_we", dmem_we, 0);
    chk("reset_addr", dmem_addr, 0);
    chk("reset_be", dmem_be, 0);
    chk("reset_wdata", dmem_wdata, 0);
    chk("reset_stall", StallM, 0);
    chk("reset_fault", MemFault, 0);
    @(posedge clk); #1;
    reset = 0;
    mon_en = 1;
    issue(0, 0, 1, 3'b000, 32'h0000_1234, 0, 5'd5, 0, 0);
    issue(1, 0, 1, 3'b000, 32'h0000_1003, $urandom, 5'd7, 0, 32'h80FF_0000);
    issue(1, 0, 1, 3'b100, 32'h0000_1003, $urandom, 5'd8, 0, 32'h80FF_0000);
    issue(0, 1, 0, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 5'd9, 3, 0);
    issue(1, 0, 1, 3'b010, 32'h0000_0001, 0, 5'd10, 0, 0);
    issue(1, 0, 1, 3'b010, 32'h0000_0040, 0, 5'd11, TO, 0);
    random_ops(250);
    mon_en = 0;
    MemReadM = 1; MemWriteM = 0; RegWriteM = 1; funct3M = 3'b010;
    ALUResultM = 32'h0000_0100; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_req", dmem_req, 1);
    reset = 1;
    MemReadM = 0;
    @(posedge clk); #1;
    reset = 0;
    dmem_ack = 1;
    dmem_rdata = $urandom;
    @(negedge clk);
    chk("post_reset_req", dmem_req, 0);
    chk("post_reset_stall", StallM, 0);
    chk("post_reset_fault", MemFault, 0);
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", StallM, 0);
    chk("late_ack_regwrite", RegWriteW_d, RegWriteM);
    @(posedge clk); #1;
    mon_en = 1;
    random_ops(30);
    mon_en = 0;
    repeat (2) @(posedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
